// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_scan_ctrl
//  Purpose  : Multiplexed 7-segment display scanner with a small register
//             file. The DATA register holds one hex nibble per digit. The CTRL
//             register holds the digit enable mask, the decimal-point mask,
//             leading-zero blanking and a global display-on bit. A prescaler
//             sets how long each digit is held before the scan moves on.
//  Ports    : clk      - clock
//             rst      - asynchronous active-high reset
//             we, re   - register write / read strobes
//             addr     - register select (0 = DATA, 1 = CTRL)
//             wstrb    - byte-lane enables for writes
//             wdata    - write data
//             rdata    - registered read data
//             led_seg  - segment drive {dp, g..a}
//             dig_sel  - one-hot digit select
//  Revision : 1.0  initial release
// ============================================================================
module seg7_scan_ctrl #(
  parameter int NUM_DIG    = 8,
  parameter int SCAN_DIV   = 20000,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic               re,
  input  logic               addr,
  input  logic [3:0]         wstrb,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic [7:0]         led_seg,
  output logic [NUM_DIG-1:0] dig_sel
);

  localparam int IDX_W = (NUM_DIG  > 1) ? $clog2(NUM_DIG)  : 1;
  localparam int PS_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(NUM_DIG - 1);
  localparam logic [PS_W-1:0]    PS_LAST  = PS_W'(SCAN_DIV - 1);

  localparam logic [31:0]        DATA_RST = 32'hDEAD_BEEF;
  localparam logic [17:0]        CTRL_RST = 18'h2_00FF;
  localparam logic [7:0]         SEG_RST  = 8'h71;
  localparam logic [NUM_DIG-1:0] SEL_RST  = NUM_DIG'(1);
  localparam logic [7:0]         INV_SEG  = {8{ACTIVE_LOW}};
  localparam logic [NUM_DIG-1:0] INV_SEL  = {NUM_DIG{ACTIVE_LOW}};

  // Only the defined CTRL bits are stored; the rest read back as zero.
  logic [31:0]        r_data;
  logic [17:0]        r_ctrl;
  logic [31:0]        w_data_wr;
  logic [17:0]        w_ctrl_wr;

  logic [PS_W-1:0]    r_presc;
  logic [IDX_W-1:0]   r_idx;

  logic [NUM_DIG-1:0] w_zero_up;
  logic [7:0]         w_en_mask;
  logic [7:0]         w_dp_mask;
  logic [3:0]         w_nib;
  logic [6:0]         w_hex;
  logic               w_show;
  logic               w_lz_blank;
  logic [7:0]         w_seg_pre;
  logic [NUM_DIG-1:0] w_sel_pre;

  logic [7:0]         r_seg_s1;
  logic [NUM_DIG-1:0] r_sel_s1;

  // --------------------------------------------------------------------------
  // Register file
  // --------------------------------------------------------------------------
  always_comb begin
    w_data_wr = r_data;
    for (int n = 0; n < 4; n++) begin
      if (wstrb[n]) w_data_wr[8*n +: 8] = wdata[8*n +: 8];
    end
    w_ctrl_wr = r_ctrl;
    if (wstrb[0]) w_ctrl_wr[7:0]   = wdata[7:0];
    if (wstrb[1]) w_ctrl_wr[15:8]  = wdata[15:8];
    if (wstrb[2]) w_ctrl_wr[17:16] = wdata[17:16];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= DATA_RST;
      r_ctrl <= CTRL_RST;
    end else if (we) begin
      if (addr) r_ctrl <= w_ctrl_wr;
      else      r_data <= w_data_wr;
    end
  end

  // Read samples the registers before any same-cycle write lands, so a
  // simultaneous read returns the old contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= 32'd0;
    end else if (re) begin
      rdata <= addr ? {14'd0, r_ctrl} : r_data;
    end
  end

  // --------------------------------------------------------------------------
  // Prescaler and digit index
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else if (r_presc == PS_LAST) begin
      r_presc <= '0;
      r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Digit decode and blanking
  // --------------------------------------------------------------------------
  // w_zero_up[i] is set when nibbles i..NUM_DIG-1 are all zero.
  always_comb begin
    w_zero_up = '0;
    w_zero_up[NUM_DIG-1] = (r_data[4*(NUM_DIG-1) +: 4] == 4'd0);
    for (int i = NUM_DIG - 2; i >= 0; i--) begin
      w_zero_up[i] = w_zero_up[i+1] & (r_data[4*i +: 4] == 4'd0);
    end
  end

  always_comb begin
    w_nib = r_data[{r_idx, 2'b00} +: 4];
    case (w_nib)
      4'h0:    w_hex = 7'h3F;
      4'h1:    w_hex = 7'h06;
      4'h2:    w_hex = 7'h5B;
      4'h3:    w_hex = 7'h4F;
      4'h4:    w_hex = 7'h66;
      4'h5:    w_hex = 7'h6D;
      4'h6:    w_hex = 7'h7D;
      4'h7:    w_hex = 7'h07;
      4'h8:    w_hex = 7'h7F;
      4'h9:    w_hex = 7'h6F;
      4'hA:    w_hex = 7'h77;
      4'hB:    w_hex = 7'h7C;
      4'hC:    w_hex = 7'h39;
      4'hD:    w_hex = 7'h5E;
      4'hE:    w_hex = 7'h79;
      default: w_hex = 7'h71;
    endcase
  end

  always_comb begin
    w_en_mask  = r_ctrl[7:0];
    w_dp_mask  = r_ctrl[15:8];
    w_show     = r_ctrl[17] & w_en_mask[r_idx];
    // Digit 0 is never leading-zero blanked so a zero value still shows "0".
    w_lz_blank = r_ctrl[16] & (r_idx != '0) & w_zero_up[r_idx];
    w_seg_pre  = (w_show && !w_lz_blank) ? {w_dp_mask[r_idx], w_hex} : 8'h00;
    w_sel_pre  = '0;
    if (w_show) w_sel_pre[r_idx] = 1'b1;
  end

  // --------------------------------------------------------------------------
  // Output pipeline: two register stages, segment and select always move
  // together. Polarity is applied last so blanked pins go all-ones when
  // active-low.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg_s1 <= SEG_RST;
      r_sel_s1 <= SEL_RST;
      led_seg  <= SEG_RST ^ INV_SEG;
      dig_sel  <= SEL_RST ^ INV_SEL;
    end else begin
      r_seg_s1 <= w_seg_pre;
      r_sel_s1 <= w_sel_pre;
      led_seg  <= r_seg_s1 ^ INV_SEG;
      dig_sel  <= r_sel_s1 ^ INV_SEL;
    end
  end

endmodule
`default_nettype wire

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 Parameter NUM_DIG, default 8: number of digits scanned; legal range 1..8.
REQ-002 Parameter SCAN_DIV, default 20000: clk cycles each digit is held; legal range >= 1.
REQ-003 Parameter ACTIVE_LOW, default 0: 1 inverts every led_seg and dig_sel bit at the output pins.
REQ-004 clk  input  1  clock.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 we  input  1  register write strobe, sampled on posedge clk.
REQ-007 re  input  1  register read strobe, sampled on posedge clk.
REQ-008 addr  input  1  register select: 0 = DATA, 1 = CTRL.
REQ-009 wstrb  input  4  byte-lane enables for a write; bit n gates wdata[8n+7:8n].
REQ-010 wdata  input  32  write data.
REQ-011 rdata  output  32  read data, registered.
REQ-012 led_seg  output  8  segment drive: bit0 = a .. bit6 = g, bit7 = dp.
REQ-013 dig_sel  output  NUM_DIG  one-hot digit select; bit i drives digit i.

Function
REQ-014 DATA[4i+3:4i] is the hex value of digit i; nibbles at or above NUM_DIG are stored and read back but never displayed.
REQ-015 CTRL fields: [7:0] digit enable mask, [15:8] decimal-point mask, [16] leading-zero blank, [17] display on; CTRL[31:18] read 0 and ignore writes.
REQ-016 Write with we=1: only lanes with wstrb bit = 1 update; the new value is visible internally on the next cycle.
REQ-017 Read with re=1: rdata holds the addressed register one cycle later and keeps it until the next read.
REQ-018 Simultaneous we and re to the same address: rdata returns the pre-write value.
REQ-019 Prescaler counts 0..SCAN_DIV-1. At SCAN_DIV-1 it returns to 0 and the digit index advances.
REQ-020 The digit index wraps from NUM_DIG-1 to 0. With SCAN_DIV=1 the index advances every cycle.
REQ-021 Hex encoding (active-high, bits g..a): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-022 led_seg[7] = CTRL dp mask bit of the current index.
REQ-023 Digit i is blanked (led_seg = 0) when any of the following holds:
- CTRL[17] = 0;
- enable mask bit i = 0;
- CTRL[16] = 1, i != 0, and nibbles i..NUM_DIG-1 are all zero.
REQ-024 dig_sel is 0 when CTRL[17] = 0 or enable bit i = 0; otherwise it is one-hot of the current index.
REQ-025 led_seg and dig_sel are registered together from the same index and register state, so the two never misalign.
REQ-026 Output latency: a register write or index change appears on the pins on the second posedge after it.
REQ-027 ACTIVE_LOW inversion is applied after all blanking logic, so blanked or deselected signals become all-ones.

Reset
REQ-028 On rst assertion, with no clock required:
- DATA = 32'hDEADBEEF; CTRL = 32'h0002_00FF;
- prescaler = 0; index = 0; rdata = 0;
- dig_sel = one-hot bit 0 and led_seg = encoding of F (71), both pre-inversion.
REQ-029 rst asserted mid-scan or mid-write discards the operation in progress; scanning restarts at digit 0 with a full SCAN_DIV dwell after release.

Verification
REQ-030 NUM_DIG=8, SCAN_DIV=4; reset, then run -> dig_sel steps 01,02,04,..,80,01, each held 4 cycles; led_seg follows F,E,E,b,D,A,E,D (71,79,79,7C,5E,77,79,5E).
REQ-031 Write DATA=0x00000120, CTRL=0x000300FF -> digits 3..7 blanked (led_seg 00, dig_sel still one-hot); digit0=3F, digit1=5B, digit2=06.
REQ-032 DATA=0x12345678, write wdata=0xAAAAAAAA, wstrb=0101 -> read DATA returns 0x12AA56AA; a simultaneous read returns 0x12345678.
REQ-033 CTRL=0x000201FE, i.e. digit 0 disabled, dp on digit 0 -> digit-0 slot: dig_sel=0, led_seg=00; other digits unchanged.
REQ-034 NUM_DIG=4, SCAN_DIV=1, ACTIVE_LOW=1 -> dig_sel cycles E,D,B,7 every clock; CTRL[17]=0 drives dig_sel=F and led_seg=FF.
REQ-035 Assert rst at index 5 mid-dwell -> outputs reach reset values immediately; after release, digit 0 is held a full 4 cycles.
